// File: rtl/vr_fifo.sv
// Synchronous valid/ready FIFO. Both handshake outputs are decoded from the
// registered occupancy only, so there is no combinational path between the two ports.
module vr_fifo #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int COUNT_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [COUNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0]   LAST = PTR_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] FULL = COUNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Explicit wrap so non-power-of-2 depths never index past the last entry.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; its content only matters while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifndef SYNTHESIS
  a_count_max: assert property (@(posedge clk) disable iff (rst) count <= FULL);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst) !(push && count == FULL));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(pop && count == '0));
`endif

endmodule

// File: tb/tb_vr_fifo.sv
// Directed bench for vr_fifo: a DEPTH=4 instance for the main sequences and a
// DEPTH=3 instance for pointer wrap and asynchronous reset mid-operation.
module tb_vr_fifo;

  logic        clk;
  logic        rst4, rst3;
  logic        iv4, ir4, ov4, or4;
  logic [31:0] id4, od4;
  logic [2:0]  cnt4;
  logic        iv3, ir3, ov3, or3;
  logic [31:0] id3, od3;
  logic [1:0]  cnt3;

  int nchecks = 0;
  int nerrors = 0;

  vr_fifo #(.WIDTH(32), .DEPTH(4)) dut4 (
    .clk(clk), .rst(rst4),
    .in_valid(iv4), .in_ready(ir4), .in_data(id4),
    .out_valid(ov4), .out_ready(or4), .out_data(od4),
    .count(cnt4)
  );

  vr_fifo #(.WIDTH(32), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst3),
    .in_valid(iv3), .in_ready(ir3), .in_data(id3),
    .out_valid(ov3), .out_ready(or3), .out_data(od3),
    .count(cnt3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_ov;
    logic        e_ir;
    logic [2:0]  e_cnt;
    logic [31:0] e_od;
  } vec_t;

  vec_t tv [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive4(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    iv4 = v; id4 = d; or4 = r;
  endtask

  task automatic drive3(input logic v, input logic [31:0] d, input logic r);
    @(negedge clk);
    iv3 = v; id3 = d; or3 = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Producer contract on dut4: data must stay put while offered and refused.
  logic        hold4 = 1'b0;
  logic [31:0] hd4   = '0;
  always @(posedge clk) begin
    if (hold4 && iv4 && id4 !== hd4) begin
      nerrors++;
      $display("FAIL upstream_hold: got %h expected %h", id4, hd4);
    end
    hold4 <= iv4 && !ir4 && !rst4;
    hd4   <= id4;
  end

  logic [31:0] exp_bp [4];

  initial begin
    tv[0] = '{1'b1, 32'hA0, 1'b0, 1'b1, 1'b1, 3'd1, 32'hA0};
    tv[1] = '{1'b1, 32'hA1, 1'b0, 1'b1, 1'b1, 3'd2, 32'hA0};
    tv[2] = '{1'b1, 32'hA2, 1'b0, 1'b1, 1'b1, 3'd3, 32'hA0};
    tv[3] = '{1'b1, 32'hA3, 1'b0, 1'b1, 1'b0, 3'd4, 32'hA0};
    tv[4] = '{1'b1, 32'hBB, 1'b0, 1'b1, 1'b0, 3'd4, 32'hA0};
    tv[5] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd3, 32'hA1};
    tv[6] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd2, 32'hA2};
    tv[7] = '{1'b0, 32'h00, 1'b1, 1'b1, 1'b1, 3'd1, 32'hA3};
    tv[8] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3'd0, 32'h00};
    tv[9] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 3'd0, 32'h00};
    exp_bp[0] = 32'hDEADBEEF; exp_bp[1] = 32'h100;
    exp_bp[2] = 32'h101;      exp_bp[3] = 32'h102;

    rst4 = 1'b1; rst3 = 1'b1;
    iv4 = 1'b0; id4 = '0; or4 = 1'b0;
    iv3 = 1'b0; id3 = '0; or3 = 1'b0;
    #3;
    check("rst_count", 32'(cnt4), 32'd0);
    check("rst_out_valid", 32'(ov4), 32'd0);
    check("rst_in_ready", 32'(ir4), 32'd1);
    @(negedge clk);
    rst4 = 1'b0; rst3 = 1'b0;

    // Fill and drain from the vector table
    for (int k = 0; k < 10; k++) begin
      drive4(tv[k].iv, tv[k].d, tv[k].ordy);
      tick();
      check($sformatf("vec%0d_count", k), 32'(cnt4), 32'(tv[k].e_cnt));
      check($sformatf("vec%0d_out_valid", k), 32'(ov4), 32'(tv[k].e_ov));
      check($sformatf("vec%0d_in_ready", k), 32'(ir4), 32'(tv[k].e_ir));
      if (tv[k].e_ov) check($sformatf("vec%0d_out_data", k), od4, tv[k].e_od);
    end

    // Latency: no same-cycle bypass when empty
    drive4(1'b1, 32'h55, 1'b0);
    #1;
    check("lat_pre_out_valid", 32'(ov4), 32'd0);
    tick();
    check("lat_post_out_valid", 32'(ov4), 32'd1);
    check("lat_post_out_data", od4, 32'h55);
    drive4(1'b0, 32'h0, 1'b1);
    tick();
    check("lat_drain_count", 32'(cnt4), 32'd0);

    // Simultaneous push/pop at count=2
    drive4(1'b1, 32'h01, 1'b0); tick();
    drive4(1'b1, 32'h02, 1'b0); tick();
    check("sim_start_count", 32'(cnt4), 32'd2);
    for (int i = 0; i < 10; i++) begin
      drive4(1'b1, 32'h10 + 32'(i), 1'b1);
      #1;
      check($sformatf("sim%0d_out_data", i), od4, (i < 2) ? 32'(i + 1) : 32'h10 + 32'(i - 2));
      tick();
      check($sformatf("sim%0d_count", i), 32'(cnt4), 32'd2);
    end
    drive4(1'b0, 32'h0, 1'b1);
    #1; check("sim_tail0", od4, 32'h18);
    tick();
    check("sim_tail1", od4, 32'h19);
    tick();
    check("sim_end_count", 32'(cnt4), 32'd0);

    // Full with out_ready=1: the pop does not open a slot in the same cycle
    for (int i = 0; i < 4; i++) begin
      drive4(1'b1, 32'hC0 + 32'(i), 1'b0);
      tick();
    end
    check("full_count", 32'(cnt4), 32'd4);
    drive4(1'b1, 32'hC4, 1'b1);
    #1; check("full_in_ready", 32'(ir4), 32'd0);
    tick();
    check("full_pop_count", 32'(cnt4), 32'd3);
    check("full_pop_head", od4, 32'hC1);
    drive4(1'b1, 32'hC4, 1'b1);
    tick();
    check("full_pp_count", 32'(cnt4), 32'd3);
    check("full_pp_head", od4, 32'hC2);
    drive4(1'b0, 32'h0, 1'b1);
    tick(); check("full_drain0", od4, 32'hC3);
    tick(); check("full_drain1", od4, 32'hC4);
    tick(); check("full_end_count", 32'(cnt4), 32'd0);

    // Backpressure: head word holds while out_ready=0
    drive4(1'b1, 32'hDEADBEEF, 1'b0); tick();
    for (int i = 0; i < 5; i++) begin
      drive4(1'b1, (i < 3) ? 32'h100 + 32'(i) : 32'h103, 1'b0);
      tick();
      check($sformatf("bp%0d_out_data", i), od4, 32'hDEADBEEF);
      check($sformatf("bp%0d_out_valid", i), 32'(ov4), 32'd1);
      check($sformatf("bp%0d_count", i), 32'(cnt4), (i + 2 > 4) ? 32'd4 : 32'(i + 2));
    end
    for (int i = 0; i < 4; i++) begin
      drive4(1'b0, 32'h0, 1'b1);
      #1; check($sformatf("bp_drain%0d", i), od4, exp_bp[i]);
      tick();
    end
    check("bp_end_count", 32'(cnt4), 32'd0);

    // DEPTH=3: interleaved push/pop so both pointers wrap
    drive3(1'b1, 32'h31, 1'b0); tick();
    check("w_e1", od3, 32'h31);
    drive3(1'b1, 32'h32, 1'b0); tick();
    check("w_e2_count", 32'(cnt3), 32'd2);
    drive3(1'b1, 32'h33, 1'b1); tick();
    check("w_e3", od3, 32'h32);
    drive3(1'b1, 32'h34, 1'b1); tick();
    check("w_e4", od3, 32'h33);
    drive3(1'b1, 32'h35, 1'b1); tick();
    check("w_e5", od3, 32'h34);
    check("w_e5_count", 32'(cnt3), 32'd2);

    // Asynchronous reset between edges
    @(negedge clk);
    iv3 = 1'b0; or3 = 1'b0;
    #2 rst3 = 1'b1;
    #1;
    check("arst_count", 32'(cnt3), 32'd0);
    check("arst_out_valid", 32'(ov3), 32'd0);
    check("arst_in_ready", 32'(ir3), 32'd1);
    #1 rst3 = 1'b0;
    drive3(1'b1, 32'h77, 1'b0); tick();
    check("arst_first_valid", 32'(ov3), 32'd1);
    check("arst_first_data", od3, 32'h77);
    check("arst_first_count", 32'(cnt3), 32'd1);
    drive3(1'b0, 32'h0, 1'b1); tick();
    check("arst_end_count", 32'(cnt3), 32'd0);
    check("arst_end_valid", 32'(ov3), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
